branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 101 ++++++++++
 tb/tb_branch_predictor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor for the fetch stage: a direct-mapped table of
// 2-bit saturating counters plus a tagged branch target buffer, trained
// by conditional branches resolving in JB, with a saturating mispredict counter.
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] IF_PC,
   output logic        IF_PredictTaken,
   output logic [31:0] IF_NextPC,
   input  logic        JB_AttemptBranch,
   input  logic [31:0] JB_PC,
   input  logic        JB_BranchTaken,
   input  logic [31:0] JB_Target,
   input  logic        mispredict,
   output logic [31:0] MispredictCount
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_LO  = INDEX_BITS + 2;
   localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

   // Counter encodings: MSB set means "predict taken".
   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] STRONG_T  = 2'b11;

   logic [1:0]          ctr_q     [ENTRIES];
   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q     [ENTRIES];
   logic [31:0]         target_q  [ENTRIES];
   logic [31:0]         mispredict_cnt_q, mispredict_cnt_d;

   logic [INDEX_BITS-1:0] if_idx, jb_idx;
   logic [TAG_BITS-1:0]   if_tag, jb_tag;
   logic                  if_hit;
   logic [1:0]            ctr_d;
   logic                  unused_jb_bits;

   assign if_idx = IF_PC[INDEX_BITS+1:2];
   assign if_tag = IF_PC[TAG_HI:TAG_LO];
   assign jb_idx = JB_PC[INDEX_BITS+1:2];
   assign jb_tag = JB_PC[TAG_HI:TAG_LO];

   // Word-offset and upper PC bits take no part in indexing or tagging.
   assign unused_jb_bits = ^{JB_PC[1:0], JB_PC[31:TAG_HI+1]};

   // Lookup against current array contents; no bypass of a same-cycle update.
   assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign IF_PredictTaken = if_hit && ctr_q[if_idx][1];
   assign IF_NextPC       = IF_PredictTaken ? target_q[if_idx] : IF_PC + 32'd4;
   assign MispredictCount = mispredict_cnt_q;

   // Next value of the trained counter, saturating at both ends.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      ctr_d = ctr_q[jb_idx];
      if (JB_BranchTaken) begin
         if (ctr_q[jb_idx] != STRONG_T) ctr_d = ctr_q[jb_idx] + 2'd1;
      end else begin
         if (ctr_q[jb_idx] != STRONG_NT) ctr_d = ctr_q[jb_idx] - 2'd1;
      end
   end

   // Saturating mispredict counter next state.
   always_comb begin
      mispredict_cnt_d = mispredict_cnt_q;
      if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF))
         mispredict_cnt_d = mispredict_cnt_q + 32'd1;
   end

   // Counters and valid bits: reset to weak-NT / invalid, trained by index only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
         valid_q <= '0;
      end else if (JB_AttemptBranch) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         ctr_q[jb_idx] <= ctr_d;
         if (JB_BranchTaken) valid_q[jb_idx] <= 1'b1;
      end
   end

   // BTB tag/target storage, written only on taken outcomes.
   always_ff @(posedge clk) begin
      // NOTE: tags and targets carry no reset; the cleared valid bit already hides stale contents.
      if (rst_n && JB_AttemptBranch && JB_BranchTaken) begin
         tag_q[jb_idx]    <= jb_tag;
         target_q[jb_idx] <= JB_Target;
      end
   end

   // Mispredict counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mispredict_cnt_q <= '0;
      else        mispredict_cnt_q <= mispredict_cnt_d;
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand-written
// reset/saturation sequences, and randomized traffic against a behavioural model.
module tb_branch_predictor;

   localparam int IB = 6;
   localparam int TB = 8;
   localparam int N  = 1 << IB;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_taken;
   logic [31:0] if_next;
   logic        jb_att;
   logic [31:0] jb_pc;
   logic        jb_tk;
   logic [31:0] jb_tgt;
   logic        mis;
   logic [31:0] mis_cnt;

   int n_checks = 0;
   int n_errors = 0;

   branch_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .IF_PC            (if_pc),
      .IF_PredictTaken  (if_taken),
      .IF_NextPC        (if_next),
      .JB_AttemptBranch (jb_att),
      .JB_PC            (jb_pc),
      .JB_BranchTaken   (jb_tk),
      .JB_Target        (jb_tgt),
      .mispredict       (mis),
      .MispredictCount  (mis_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_ctr   [N];   // 0..3, taken when >= 2
   bit          m_valid [N];
   int unsigned m_tag   [N];
   logic [31:0] m_tgt   [N];
   longint      m_cnt;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return (pc >> (IB + 2)) % (1 << TB);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_ctr[i]   = 1;
         m_valid[i] = 1'b0;
      end
      m_cnt = 0;
   endfunction

   function automatic bit model_taken(input logic [31:0] pc);
      int i = idx_of(pc);
      return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] model_next(input logic [31:0] pc);
      return model_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
   endfunction

   function automatic void model_update(input bit att, input logic [31:0] bpc, input bit tk,
                                        input logic [31:0] tgt, input bit mp);
      int i = idx_of(bpc);
      if (att) begin
         if (tk) begin
            m_ctr[i]   = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(bpc);
            m_tgt[i]   = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end
      if (mp && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] pc;
      logic        att;
      logic [31:0] bpc;
      logic        tk;
      logic [31:0] tgt;
      logic        mp;
      logic        exp_taken;
      logic [31:0] exp_next;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(input logic [31:0] pc, input logic att, input logic [31:0] bpc,
                               input logic tk, input logic [31:0] tgt, input logic mp,
                               input logic et, input logic [31:0] en, input logic [31:0] ec);
      vec_t v;
      v.pc = pc; v.att = att; v.bpc = bpc; v.tk = tk; v.tgt = tgt; v.mp = mp;
      v.exp_taken = et; v.exp_next = en; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic drive(input logic [31:0] pc, input logic att, input logic [31:0] bpc,
                        input logic tk, input logic [31:0] tgt, input logic mp);
      if_pc = pc; jb_att = att; jb_pc = bpc; jb_tk = tk; jb_tgt = tgt; mis = mp;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      model_reset();

      // pc, att, jb_pc, taken, target, mispredict -> taken, next, count
      vecs[0]  = mk(32'h0000_0000, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0000_0004, 0);
      vecs[1]  = mk(32'h0000_0100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0000_0104, 0);
      vecs[2]  = mk(32'hFFFF_FFFC, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0000_0000, 0);
      vecs[3]  = mk(32'h0000_0040, 1, 32'h40,  1, 32'h80,  0, 0, 32'h0000_0044, 0); // same-cycle: pre-update
      vecs[4]  = mk(32'h0000_0040, 1, 32'h40,  1, 32'h80,  0, 1, 32'h0000_0080, 0);
      vecs[5]  = mk(32'h0000_0040, 1, 32'h40,  1, 32'h80,  0, 1, 32'h0000_0080, 0);
      vecs[6]  = mk(32'h0000_0040, 1, 32'h40,  1, 32'h80,  0, 1, 32'h0000_0080, 0);
      vecs[7]  = mk(32'h0000_0040, 1, 32'h40,  1, 32'h80,  0, 1, 32'h0000_0080, 0);
      vecs[8]  = mk(32'h0000_0040, 1, 32'h40,  0, 32'h0,   0, 1, 32'h0000_0080, 0); // 11 -> 10
      vecs[9]  = mk(32'h0000_0040, 1, 32'h40,  0, 32'h0,   0, 1, 32'h0000_0080, 0); // 10 -> 01
      vecs[10] = mk(32'h0000_0040, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0000_0044, 0);
      vecs[11] = mk(32'h0000_0040, 1, 32'h40,  1, 32'h80,  0, 0, 32'h0000_0044, 0); // 01 -> 10
      vecs[12] = mk(32'h0000_0140, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0000_0144, 0); // alias, tag miss
      vecs[13] = mk(32'h0000_0040, 1, 32'h140, 1, 32'h200, 0, 1, 32'h0000_0080, 0); // alias replaces BTB
      vecs[14] = mk(32'h0000_0040, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0000_0044, 0);
      vecs[15] = mk(32'h0000_0140, 0, 32'h0,   0, 32'h0,   0, 1, 32'h0000_0200, 0);
      vecs[16] = mk(32'h0000_0000, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0000_0004, 0);
      vecs[17] = mk(32'h0000_0000, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0000_0004, 1);
      vecs[18] = mk(32'h0000_0000, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0000_0004, 2);
      vecs[19] = mk(32'h0000_0000, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0000_0004, 3);

      // Outputs held in reset regardless of a pending update.
      repeat (2) @(negedge clk);
      drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
      #1;
      check("in_reset_taken", {31'b0, if_taken}, 32'h0);
      check("in_reset_next",  if_next, 32'h44);
      check("in_reset_cnt",   mis_cnt, 32'h0);
      @(negedge clk);
      drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b1;

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drive(vecs[k].pc, vecs[k].att, vecs[k].bpc, vecs[k].tk, vecs[k].tgt, vecs[k].mp);
         #1;
         check($sformatf("vec%0d_taken", k), {31'b0, if_taken}, {31'b0, vecs[k].exp_taken});
         check($sformatf("vec%0d_next", k),  if_next, vecs[k].exp_next);
         check($sformatf("vec%0d_cnt", k),   mis_cnt, vecs[k].exp_cnt);
      end

      // Mid-training asynchronous reset: index 0x10 holds strong-T, tag of 0x140, target 0x200.
      @(negedge clk);
      drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0);
      #1;
      check("pre_rst_taken", {31'b0, if_taken}, 32'h1);
      check("pre_rst_next",  if_next, 32'h200);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_taken", {31'b0, if_taken}, 32'h0);
      check("async_rst_next",  if_next, 32'h144);
      check("async_rst_cnt",   mis_cnt, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      check("post_rst_taken", {31'b0, if_taken}, 32'h0);
      check("post_rst_next",  if_next, 32'h144);
      @(negedge clk);
      drive(32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0);
      @(negedge clk);
      drive(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      check("weak_nt_reset_taken", {31'b0, if_taken}, 32'h1);
      check("weak_nt_reset_next",  if_next, 32'h300);

      // Randomized traffic against the model, starting from a fresh reset.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 400; k++) begin
         logic [31:0] pc, bpc, tgt;
         logic        att, tk, mp;
         pc  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
               : ((32'($urandom_range(0, 2)) << (IB + 2)) | (32'($urandom_range(0, 3)) << 2));
         bpc = ((32'($urandom_range(0, 2)) << (IB + 2)) | (32'($urandom_range(0, 3)) << 2));
         tgt = $urandom & 32'hFFFF_FFFC;
         att = ($urandom_range(0, 2) != 0);
         tk  = ($urandom_range(0, 3) != 0);
         mp  = $urandom_range(0, 1) == 1;
         @(negedge clk);
         drive(pc, att, bpc, tk, tgt, mp);
         #1;
         check($sformatf("rnd%0d_taken", k), {31'b0, if_taken}, {31'b0, model_taken(pc)});
         check($sformatf("rnd%0d_next", k),  if_next, model_next(pc));
         check($sformatf("rnd%0d_cnt", k),   mis_cnt, m_cnt[31:0]);
         model_update(att, bpc, tk, tgt, mp);
      end

      // Mispredict counter saturation from a preloaded value.
      @(negedge clk);
      drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      force dut.mispredict_cnt_q = 32'hFFFF_FFFD;
      #1 release dut.mispredict_cnt_q;
      #1;
      m_cnt = 64'hFFFF_FFFD;
      check("sat_preload", mis_cnt, m_cnt[31:0]);
      mis = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         model_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
         check($sformatf("sat%0d_cnt", k), mis_cnt, m_cnt[31:0]);
      end
      mis = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
